// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the 8N1 UART receiver.
//   uart_rx_state_e : receiver FSM state encoding (also exported for debug)
//   OVERSAMPLE      : ticks per bit period
//   MID_SAMPLE      : ticks from start-bit edge to mid start bit
//   DATA_BITS       : payload bits per frame
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    // Counter compare values, sized for the 4-bit oversample counter and
    // the 3-bit bit index.
    localparam logic [3:0] LAST_OS_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_OS_TICK  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator. A 32-bit counter runs 0..div and emits a
// one-clock tick on the div count, then wraps to 0. div = 0 ticks every
// clock. The divider value is captured at the start of each period, so a
// change on div_i takes effect at the next wrap.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset
//   clken_i : enable; 0 holds the counter cleared and suppresses ticks
//   div_i   : divider (one tick every div_i+1 clocks)
//   tick_o  : one-clock oversample tick
// ---------------------------------------------------------------------------
module uart_baud_tick (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clken_i,
    input  logic [31:0] div_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic [31:0] lim;

    always_comb begin
        // At count 0 a fresh period begins: take the live divider. Inside a
        // period keep comparing against the value captured at its start.
        lim    = (cnt_q == 32'd0) ? div_i : div_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_o = 1'b0;
        if (!clken_i) begin
            cnt_d = 32'd0;
        end else begin
            div_d = lim;
            if (cnt_q == lim) begin
                tick_o = 1'b1;
                cnt_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 32'd0;
            div_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with 16x oversampling and a programmable baud divider.
// Each good frame is delivered on data with a sticky rdy flag.
//
// Handshake: rdy rises in the clock the stop bit is accepted and data is
// updated in that same clock. rdy stays high until the consumer pulses
// rdy_clr for one clock; it then drops on the next edge. A byte completing
// in the same clock as rdy_clr wins (rdy stays 1, data takes the new byte).
// A byte arriving while rdy is already set overwrites data (no overrun flag).
//
// Parameters:
//   p_ext_clk    : 0 = divider is p_def_scaler, 1 = divider is scaler port
//   p_def_scaler : fixed divider used when p_ext_clk = 0
// Ports:
//   clk_50m : system clock (rising edge)
//   rst     : synchronous active-high reset
//   clken   : receiver enable; 0 aborts any frame and forces IDLE
//   rx      : serial input, idle high
//   scaler  : oversample divider (one tick every scaler+1 clocks)
//   rdy_clr : one-clock pulse clears rdy
//   rdy     : byte available (sticky)
//   data    : last received byte
//   state_o : current FSM state (debug visibility)
// Build option:
//   UART_RX_SYNC_EN : when defined, rx goes through a 2-flop synchroniser
//                     (reset to 1) before the FSM, adding 2 clocks of latency.
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_rx_pkg::*;
#(
    parameter int          p_ext_clk    = 0,
    parameter int unsigned p_def_scaler = 26
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        clken,
    input  logic        rx,
    input  logic [31:0] scaler,
    input  logic        rdy_clr,
    output logic        rdy,
    output logic [7:0]  data,
    output logic [1:0]  state_o
);

    localparam logic [31:0] DEF_DIV = 32'(p_def_scaler);

    logic [31:0] div;
    logic        tick;
    logic        rx_s;

    assign div = (p_ext_clk != 0) ? scaler : DEF_DIV;

    uart_baud_tick u_baud_tick (
        .clk_i   (clk_50m),
        .rst_i   (rst),
        .clken_i (clken),
        .div_i   (div),
        .tick_o  (tick)
    );

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    uart_rx_state_e state_q, state_d;
    logic [3:0]     os_cnt_q, os_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           rdy_q, rdy_d;
    logic [7:0]     data_q, data_d;
    logic           byte_done;

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rdy_d     = rdy_q;
        data_d    = data_q;
        byte_done = 1'b0;

        if (!clken) begin
            state_d   = ST_IDLE;
            os_cnt_d  = 4'd0;
            bit_idx_d = 3'd0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d  = ST_START;
                        os_cnt_d = 4'd0;
                    end
                end
                ST_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (os_cnt_q == MID_OS_TICK) begin
                        os_cnt_d  = 4'd0;
                        bit_idx_d = 3'd0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    // Sampling one full bit period after mid start keeps
                    // every data sample centred in its bit.
                    if (os_cnt_q == LAST_OS_TICK) begin
                        os_cnt_d           = 4'd0;
                        shift_d[bit_idx_q] = rx_s;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    // A low stop bit is a framing error: drop the byte.
                    if (os_cnt_q == LAST_OS_TICK) begin
                        os_cnt_d  = 4'd0;
                        state_d   = ST_IDLE;
                        byte_done = rx_s;
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A completing byte takes priority over a simultaneous clear.
        if (byte_done) begin
            rdy_d  = 1'b1;
            data_d = shift_q;
        end else if (rdy_clr) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            os_cnt_q  <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            rdy_q     <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rdy_q     <= rdy_d;
            data_q    <= data_d;
        end
    end

    assign rdy     = rdy_q;
    assign data    = data_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver (p_ext_clk = 1). A driver task serialises
// 8N1 frames onto rx and pushes the expected byte into exp_q; a monitor pops
// and compares on every rising edge of rdy. Cases that do not produce a rdy
// edge (overrun, clear-vs-complete collision, aborted frames) are checked
// directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        clken;
    logic        rx;
    logic [31:0] scaler;
    logic        rdy_clr;
    logic        rdy;
    logic [7:0]  data;
    logic [1:0]  state_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    bit          auto_clr = 1'b0;
    bit          rdy_prev = 1'b0;
    int          lat_k;
    logic [7:0]  mon_exp;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Negedges from driving the start edge until rdy is seen high:
    // one to reach the first tick, then 152 ticks at one tick per clock.
    localparam int LAT = 153 + SYNC_LAT;

    // ---------------- clock ----------------
    always #5 clk_50m = ~clk_50m;

    uart_receiver #(
        .p_ext_clk    (1),
        .p_def_scaler (26)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .clken   (clken),
        .rx      (rx),
        .scaler  (scaler),
        .rdy_clr (rdy_clr),
        .rdy     (rdy),
        .data    (data),
        .state_o (state_o)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input int budget, input string name);
        int k;
        k = 0;
        while (!rdy && k < budget) begin
            @(negedge clk_50m);
            k++;
        end
        n_tests++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL %s: rdy=0 after %0d clocks, expected 1", name, budget);
        end
    endtask

    // Called at a negedge; every bit lasts cpb clocks, line left idle high.
    task automatic send_byte(input logic [7:0] b, input int cpb, input bit stop_bit, input bit push);
        if (push) exp_q.push_back(b);
        rx = 1'b0;
        repeat (cpb) @(negedge clk_50m);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk_50m);
        end
        rx = stop_bit;
        repeat (cpb) @(negedge clk_50m);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_50m);
            if (rdy && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: data=%0h with no byte expected", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_byte", {24'd0, data}, {24'd0, mon_exp});
                end
            end
            rdy_prev = rdy;
        end
    end

    // Consumer that clears rdy as soon as it is seen (stream test only).
    initial begin
        forever begin
            @(negedge clk_50m);
            if (auto_clr) rdy_clr = rdy;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        clken   = 1'b1;
        rx      = 1'b1;
        scaler  = 32'd0;
        rdy_clr = 1'b0;

        // Reset and idle line
        repeat (2) @(negedge clk_50m);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_state", {30'd0, state_o}, 32'd0);
        rst = 1'b0;
        repeat (1000) @(negedge clk_50m);
        check("idle_rdy", {31'd0, rdy}, 32'd0);
        check("idle_state", {30'd0, state_o}, 32'd0);

        // Single byte at 16 clocks/bit, with latency
        fork
            send_byte(8'h41, 16, 1'b1, 1'b1);
            begin
                lat_k = 0;
                while (!rdy && lat_k < 400) begin
                    @(negedge clk_50m);
                    lat_k++;
                end
                check("latency_41", lat_k, LAT);
            end
        join
        pulse_clr();
        check("rdy_clr", {31'd0, rdy}, 32'd0);

        // Back-to-back stream at 64 clocks/bit
        scaler   = 32'd3;
        auto_clr = 1'b1;
        repeat (10) @(negedge clk_50m);
        send_byte(8'h0D, 64, 1'b1, 1'b1);
        send_byte(8'h0A, 64, 1'b1, 1'b1);
        send_byte(8'hFF, 64, 1'b1, 1'b1);
        send_byte(8'h00, 64, 1'b1, 1'b1);
        repeat (100) @(negedge clk_50m);
        auto_clr = 1'b0;
        rdy_clr  = 1'b0;
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_rdy", {31'd0, rdy}, 32'd0);

        // Start-bit glitch of 4 ticks
        scaler = 32'd0;
        repeat (10) @(negedge clk_50m);
        rx = 1'b0;
        repeat (4) @(negedge clk_50m);
        rx = 1'b1;
        repeat (20) @(negedge clk_50m);
        check("glitch_state", {30'd0, state_o}, 32'd0);
        check("glitch_rdy", {31'd0, rdy}, 32'd0);

        // Framing error: stop bit low
        send_byte(8'h3C, 16, 1'b0, 1'b0);
        repeat (30) @(negedge clk_50m);
        check("frame_rdy", {31'd0, rdy}, 32'd0);
        check("frame_data", {24'd0, data}, 32'h00);
        check("frame_state", {30'd0, state_o}, 32'd0);

        // Overrun: second byte overwrites while rdy is still set
        send_byte(8'h55, 16, 1'b1, 1'b1);
        wait_rdy(50, "ovr_55_rdy");
        send_byte(8'hAA, 16, 1'b1, 1'b0);
        check("ovr_data", {24'd0, data}, 32'hAA);
        check("ovr_rdy", {31'd0, rdy}, 32'd1);

        // rdy_clr in the completion clock: the byte wins
        fork
            send_byte(8'hC3, 16, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(negedge clk_50m);
                rdy_clr = 1'b1;
                @(negedge clk_50m);
                rdy_clr = 1'b0;
                check("sim_rdy", {31'd0, rdy}, 32'd1);
                check("sim_data", {24'd0, data}, 32'hC3);
            end
        join
        pulse_clr();
        check("sim_clr", {31'd0, rdy}, 32'd0);

        // Drop clken mid-frame, then receive normally
        fork
            send_byte(8'h3C, 16, 1'b1, 1'b0);
            begin
                repeat (60) @(negedge clk_50m);
                clken = 1'b0;
                repeat (3) @(negedge clk_50m);
                check("en_state", {30'd0, state_o}, 32'd0);
            end
        join
        repeat (5) @(negedge clk_50m);
        check("en_rdy", {31'd0, rdy}, 32'd0);
        check("en_data", {24'd0, data}, 32'hC3);
        clken = 1'b1;
        send_byte(8'h5A, 16, 1'b1, 1'b1);
        wait_rdy(40, "en_5a_rdy");

        // Reset mid-frame with rdy still set from 5A
        fork
            send_byte(8'h96, 16, 1'b1, 1'b0);
            begin
                repeat (80) @(negedge clk_50m);
                rst = 1'b1;
                @(negedge clk_50m);
                check("rst_state", {30'd0, state_o}, 32'd0);
                check("rst_data", {24'd0, data}, 32'h00);
                check("rst_rdy", {31'd0, rdy}, 32'd0);
            end
        join
        rst = 1'b0;
        repeat (20) @(negedge clk_50m);
        check("final_rdy", {31'd0, rdy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
